spi_slave_control: RTL

//  SPI responder for the spi_master_control link: mode 3 (SPI_CLK idles high, data driven on falling

---
 rtl/spi_slave_control.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/spi_slave_control.sv
// SPI mode-3 responder: oversamples SPI_CLK/SPI_CS_N/SPI_MO in the clk domain,
// shifts tx_data out MSB first on SPI_MI and collects SPI_MO into rx_data.
module spi_slave_control #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SPI_CLK,
  input  logic              SPI_CS_N,
  input  logic              SPI_MO,
  output logic              SPI_MI,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_taken,
  output logic [DATA_W-1:0] rx_data,
  output logic [5:0]        rx_bits,
  output logic              rx_valid,
  output logic              rx_ovf,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic [SYNC_STAGES-1:0] mo_sync_reg;
  logic                   d_clk_reg;

  logic s_clk, s_cs, s_mo;
  logic rise, fall;

  logic [DATA_W-1:0] tx_sh_reg;
  logic [DATA_W-1:0] rx_sh_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              ovf_reg;
  logic              mi_reg;
  logic              busy_reg;
  logic [DATA_W-1:0] rx_data_reg;
  logic [5:0]        rx_bits_reg;
  logic              rx_ovf_reg;
  logic              rx_valid_reg;
  logic              tx_taken_c;

  // Synchronizers preset to the idle bus levels so reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_reg <= '1;
      cs_sync_reg  <= '1;
      mo_sync_reg  <= '0;
      d_clk_reg    <= 1'b1;
    end else begin
      clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], SPI_CLK};
      cs_sync_reg  <= {cs_sync_reg[SYNC_STAGES-2:0], SPI_CS_N};
      mo_sync_reg  <= {mo_sync_reg[SYNC_STAGES-2:0], SPI_MO};
      d_clk_reg    <= clk_sync_reg[SYNC_STAGES-1];
    end
  end

  assign s_clk = clk_sync_reg[SYNC_STAGES-1];
  assign s_cs  = cs_sync_reg[SYNC_STAGES-1];
  assign s_mo  = mo_sync_reg[SYNC_STAGES-1];
  assign rise  = s_clk & ~d_clk_reg;
  assign fall  = ~s_clk & d_clk_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // CS is tested as a level so a re-select that lands during DONE is still seen in IDLE.
  always_comb begin
    state_next = state_reg;
    tx_taken_c = 1'b0;
    case (state_reg)
      IDLE:  if (!s_cs) state_next = LOAD;
      LOAD: begin
        tx_taken_c = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: if (s_cs) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sh_reg    <= '0;
      rx_sh_reg    <= '0;
      cnt_reg      <= '0;
      ovf_reg      <= 1'b0;
      mi_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      rx_data_reg  <= '0;
      rx_bits_reg  <= '0;
      rx_ovf_reg   <= 1'b0;
      rx_valid_reg <= 1'b0;
    end else begin
      rx_valid_reg <= (state_reg == DONE);
      case (state_reg)
        LOAD: begin
          tx_sh_reg <= tx_data;
          rx_sh_reg <= '0;
          cnt_reg   <= '0;
          ovf_reg   <= 1'b0;
          busy_reg  <= 1'b1;
        end
        SHIFT: begin
          // An edge coinciding with CS deassertion is dropped.
          if (!s_cs) begin
            if (fall) begin
              mi_reg    <= tx_sh_reg[DATA_W-1];
              tx_sh_reg <= tx_sh_reg << 1;
            end
            if (rise) begin
              rx_sh_reg <= DATA_W'({rx_sh_reg, s_mo});
              if (cnt_reg == CNT_W'(DATA_W)) ovf_reg <= 1'b1;
              else                           cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end
        DONE: begin
          rx_data_reg <= rx_sh_reg;
          rx_bits_reg <= 6'(cnt_reg);
          rx_ovf_reg  <= ovf_reg;
          busy_reg    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign SPI_MI   = mi_reg;
  assign tx_taken = tx_taken_c;
  assign rx_data  = rx_data_reg;
  assign rx_bits  = rx_bits_reg;
  assign rx_valid = rx_valid_reg;
  assign rx_ovf   = rx_ovf_reg;
  assign busy     = busy_reg;

endmodule
